// File: rtl/axi_wr_master.sv
// axi_wr_master: single-outstanding AXI4 write master.
// Takes one command (id/addr/len), issues AW, streams len+1 W beats from the
// write-data source, waits for B and reports it as a one-cycle response pulse.
module axi_wr_master #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // command
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  // write-data source
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  // response
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [1:0]          rsp_resp,
  // AW
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  // W
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // B
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // status
  output logic                busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W/8));

  logic [1:0]        r_state;
  logic              r_live;      // low until the first edge after reset release
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_awvalid;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [1:0]        r_rsp_resp;

  logic w_in_w;
  logic w_cmd_fire;
  logic w_w_fire;
  logic w_last;

  assign w_in_w     = (r_state == S_W);
  assign w_last     = w_in_w && (r_cnt == r_len);
  assign w_w_fire   = WVALID && WREADY;
  // The response cycle blocks acceptance so a new command starts a cycle later.
  assign cmd_ready  = r_live && (r_state == S_IDLE) && !r_rsp_valid;
  assign w_cmd_fire = cmd_valid && cmd_ready;

  assign AWID    = r_id;
  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWSIZE  = AXSIZE;
  assign AWBURST = 2'b01;
  assign AWVALID = r_awvalid;

  // W channel is a straight pass-through of the data source, gated by state.
  assign WVALID   = w_in_w && wd_valid;
  assign wd_ready = w_in_w && WREADY;
  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign WLAST    = w_last;

  assign BREADY    = (r_state == S_B);
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_resp  = r_rsp_resp;
  assign busy      = (r_state != S_IDLE);

  // Transaction FSM: IDLE -> AW -> W -> B -> IDLE, with beat counting and response capture.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_awvalid   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_live      <= 1'b1;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_id      <= cmd_id;
            r_addr    <= cmd_addr;
            r_len     <= cmd_len;
            r_cnt     <= '0;
            r_awvalid <= 1'b1;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (AWREADY) begin
            r_awvalid <= 1'b0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_w_fire) begin
            if (w_last) r_state <= S_B;
            else        r_cnt   <= r_cnt + 8'd1;
          end
        end
        S_B: begin
          if (BVALID) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= BID;
            r_rsp_resp  <= BRESP;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_master.md
AXI_WR_MASTER -- requirements
Module: axi_wr_master

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of the AXI ID fields.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter DATA_W, default 32, data bus width, legal values 32, 64 or 128.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ACLK (input, 1, clock, rising edge) and ARESETn (input, 1, asynchronous active-low reset).
REQ-005 SHALL have these command ports:
- cmd_valid: input, 1, command request.
- cmd_ready: output, 1, command accept.
- cmd_id: input, ID_W, transaction ID.
- cmd_addr: input, ADDR_W, start address, DATA_W/8 aligned.
- cmd_len: input, 8, beat count minus 1.
REQ-006 SHALL have these write-data source ports: wd_valid (input, 1), wd_ready (output, 1), wd_data (input, DATA_W), wd_strb (input, DATA_W/8).
REQ-007 SHALL have these response ports: rsp_valid (output, 1, one-cycle pulse), rsp_id (output, ID_W), rsp_resp (output, 2).
REQ-008 SHALL have these AW ports:
- AWID: output, ID_W.
- AWADDR: output, ADDR_W.
- AWLEN: output, 8.
- AWSIZE: output, 3.
- AWBURST: output, 2.
- AWVALID: output, 1.
- AWREADY: input, 1.
REQ-009 SHALL have these W ports: WDATA (output, DATA_W), WSTRB (output, DATA_W/8), WLAST (output, 1), WVALID (output, 1), WREADY (input, 1).
REQ-010 SHALL have these B ports: BID (input, ID_W), BRESP (input, 2), BVALID (input, 1), BREADY (output, 1).
REQ-011 SHALL have a busy output, 1 bit, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, AW, W, B, with one transaction outstanding at a time.
REQ-013 SHALL, in IDLE, drive cmd_ready=1; on cmd_valid&&cmd_ready it SHALL register id/addr/len, clear the beat counter and go to AW on the next cycle.
REQ-014 SHALL, in AW, drive AWVALID=1 from a register with AWID/AWADDR/AWLEN stable; on AWVALID&&AWREADY it SHALL go to W.
REQ-015 SHALL hold AWVALID until AWREADY and SHALL NOT deassert it early; AWVALID SHALL NOT depend combinationally on AWREADY.
REQ-016 SHALL drive AWSIZE=log2(DATA_W/8) and AWBURST=2'b01 (INCR) constantly.
REQ-017 SHALL NOT start W beats before the AW handshake has completed.
REQ-018 SHALL, in W, drive WVALID=wd_valid, WDATA=wd_data, WSTRB=wd_strb and wd_ready=WREADY; outside W, WVALID=0 and wd_ready=0.
REQ-019 SHALL count W beats with an 8-bit counter; WLAST=1 exactly when counter==registered len in state W.
REQ-020 SHALL, on a WVALID&&WREADY&&WLAST handshake, go to B; on other handshakes the counter SHALL increment by 1.
REQ-021 SHALL, in B, drive BREADY=1; on BVALID it SHALL pulse rsp_valid for one cycle with rsp_id=BID and rsp_resp=BRESP (registered), and return to IDLE.
REQ-022 SHALL NOT check BID against the issued ID; a mismatch is reported as received.
REQ-023 SHALL ignore BVALID outside B, with BREADY=0 there.
REQ-024 SHALL NOT accept a new command in the cycle rsp_valid is asserted; cmd_ready rises on the following cycle.
REQ-025 SHALL NOT check 4KB boundary crossing; commands must not cross 4KB.
REQ-026 SHALL, for len=0, assert WLAST on the first beat.
REQ-027 SHALL, for len=255, assert WLAST on the 256th beat with no counter wrap before it.

Reset
REQ-028 SHALL, on ARESETn low, immediately (asynchronously) go to IDLE with AWVALID=0, WVALID=0, BREADY=0, rsp_valid=0, busy=0, beat counter=0 and all registered fields=0.
REQ-029 SHALL, while in reset, drive cmd_ready=0; cmd_ready=1 is allowed from the first ACLK edge after ARESETn deasserts.
REQ-030 SHALL abandon any in-flight transaction on reset mid-operation, with no response issued.

Verification
REQ-031 SHALL be verified by a single beat: cmd id=3, addr=0x1000, len=0, AWREADY=1, WREADY=1, BVALID with BRESP=0 -> AWLEN=0, one beat with WLAST=1, rsp_valid pulse with rsp_id=3, rsp_resp=0.
REQ-032 SHALL be verified by backpressure: len=3, AWREADY low for 5 cycles, WREADY toggling -> AW fields stable during the stall, exactly 4 W beats, WLAST only on the 4th.
REQ-033 SHALL be verified by a max burst: len=255 -> 256 beats, WLAST on beat 256, single response.
REQ-034 SHALL be verified by an error response: BRESP=2'b10, BID=5 -> rsp_resp=2'b10, rsp_id=5.
REQ-035 SHALL be verified by reset mid-W: ARESETn low after beat 2 of 8 -> all valids 0 the same cycle; a new command after release completes normally.
REQ-036 SHALL be verified by back-to-back commands: cmd_valid held high -> second accept no earlier than the cycle after rsp_valid, and no AW issued before the first B.
